// File: rtl/diff_arb.sv
// Two-channel frame arbiter feeding the differential DNA-word encoder.
// One frame is granted at a time, and the output is a single registered stage.
module diff_arb #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2*N-1:0] s0_data,
  input  logic           s0_valid,
  input  logic           s0_last,
  output logic           s0_ready,
  input  logic [2*N-1:0] s1_data,
  input  logic           s1_valid,
  input  logic           s1_last,
  output logic           s1_ready,
  output logic [2*N-1:0] m_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic           m_last,
  output logic           m_ch,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [1:0]     carry;
  logic           last_served;
  logic           out_free;
  logic           acc0;
  logic           acc1;
  logic           acc;
  logic           acc_last;
  logic           gnt_entry;
  logic [2*N-1:0] in_word;
  logic [2*N-1:0] enc_word;
  logic [1:0]     enc_prev;

  assign out_free = !m_valid || m_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    if (rst_n) begin
      s0_ready = (state == GNT0) && out_free;
      s1_ready = (state == GNT1) && out_free;
    end
  end

  assign acc0     = s0_valid && s0_ready;
  assign acc1     = s1_valid && s1_ready;
  assign acc      = acc0 || acc1;
  assign in_word  = acc1 ? s1_data : s0_data;
  assign acc_last = acc1 ? s1_last : s0_last;

  // Each base minus its predecessor, mod 4; base 0 uses the carry.
  always_comb begin
    enc_word = '0;
    enc_prev = carry;
    for (int k = 0; k < N; k++) begin
      enc_word[2*N-1-2*k -: 2] =
        in_word[2*N-1-2*k -: 2] - enc_prev;
      enc_prev = in_word[2*N-1-2*k -: 2];
    end
  end

  always_comb begin
    state_nx  = state;
    gnt_entry = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          s0_valid && !s1_valid: state_nx = GNT0;
          !s0_valid && s1_valid: state_nx = GNT1;
          s0_valid && s1_valid:
            state_nx = last_served ? GNT0 : GNT1;
          default: state_nx = IDLE;
        endcase
        gnt_entry = (state_nx != IDLE);
      end
      GNT0: if (acc0 && s0_last) state_nx = IDLE;
      GNT1: if (acc1 && s1_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      carry       <= 2'd0;
      last_served <= 1'b1;
    end else begin
      state <= state_nx;
      if (gnt_entry)
        carry <= 2'd0;
      else if (acc)
        carry <= in_word[1:0];
      if (acc && acc_last)
        last_served <= acc1;
    end
  end

  // Output holds under backpressure; a drain plus accept reloads in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_ch    <= 1'b0;
    end else if (acc) begin
      m_valid <= 1'b1;
      m_data  <= enc_word;
      m_last  <= acc_last;
      m_ch    <= acc1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_diff_arb.sv
// Scoreboard bench for diff_arb: reference encoder and
// grant rules model, directed plan cases plus random traffic.
module tb_diff_arb;

  typedef struct {
    logic [15:0] d;
    logic        l;
    bit          g_en;
    logic [15:0] g;
  } wrd_t;

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic        c;
    bit          g_en;
    logic [15:0] g;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sd [2];
  logic        sv [2];
  logic        sl [2];
  logic        srdy [2];
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        m_ch;
  logic        busy;

  int   errors = 0;
  int   checks = 0;
  wrd_t inq [2][$];
  exp_t sb [$];
  bit   frame_order [$];
  bit   hs [2];
  int   acc_cnt = 0;
  bit   vmode = 1'b1;
  int   mr_mode = 1;

  diff_arb #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_data(sd[0]), .s0_valid(sv[0]),
    .s0_last(sl[0]), .s0_ready(srdy[0]),
    .s1_data(sd[1]), .s1_valid(sv[1]),
    .s1_last(sl[1]), .s1_ready(srdy[1]),
    .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last),
    .m_ch(m_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] ref_enc(
      input logic [15:0] w, input int c);
    logic [15:0] r;
    int prev, b;
    r = '0;
    prev = c;
    for (int k = 0; k < 8; k++) begin
      b = int'(w[15-2*k -: 2]);
      r[15-2*k -: 2] = 2'((b - prev + 4) % 4);
      prev = b;
    end
    return r;
  endfunction

  // Driver: hold the head word until it is taken.
  initial begin
    sv[0] = 0; sv[1] = 0; sl[0] = 0; sl[1] = 0;
    sd[0] = 0; sd[1] = 0;
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < 2; c++) begin
        if (hs[c] && inq[c].size() > 0)
          void'(inq[c].pop_front());
        if (inq[c].size() > 0 &&
            (vmode || $urandom_range(3) != 0)) begin
          sv[c] = 1'b1;
          sd[c] = inq[c][0].d;
          sl[c] = inq[c][0].l;
        end else begin
          sv[c] = 1'b0;
        end
      end
      case (mr_mode)
        0: m_ready = ($urandom_range(3) != 0);
        1: m_ready = 1'b1;
        default: m_ready = 1'b0;
      endcase
    end
  end

  bit          idle_m, ls_m, g_m;
  int          carry_m;
  bit          prev_stall;
  logic [17:0] prev_out;
  exp_t        e;
  wrd_t        w;

  // Monitor: grant rules, handshakes, scoreboard.
  always @(negedge clk) begin
    hs[0] = sv[0] && srdy[0];
    hs[1] = sv[1] && srdy[1];
    if (!rst_n) begin
      idle_m = 1; ls_m = 1; carry_m = 0;
      sb.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall)
        chk(m_valid && {m_ch, m_last, m_data} == prev_out,
            "hold", 32'({m_valid, m_ch, m_last, m_data}),
            32'({1'b1, prev_out}));
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk(0, "spurious_out", 32'(m_data), 0);
        end else begin
          e = sb.pop_front();
          chk({m_ch, m_last, m_data} == {e.c, e.l, e.d},
              "out_word", 32'({m_ch, m_last, m_data}),
              32'({e.c, e.l, e.d}));
          if (e.g_en)
            chk(m_data == e.g, "plan_word",
                32'(m_data), 32'(e.g));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_out = {m_ch, m_last, m_data};
      if (idle_m) begin
        chk(!srdy[0] && !srdy[1] && !busy, "idle_gate",
            32'({srdy[1], srdy[0], busy}), 0);
        if (sv[0] || sv[1]) begin
          g_m = (sv[0] && sv[1]) ? !ls_m : sv[1];
          idle_m = 0;
          carry_m = 0;
          frame_order.push_back(g_m);
        end
      end else begin
        chk(srdy[g_m] == (!m_valid || m_ready) &&
            !srdy[!g_m] && busy, "grant_ready",
            32'({srdy[1], srdy[0], busy}),
            32'({g_m, !g_m, 1'b1}));
        if (hs[g_m] && inq[g_m].size() > 0) begin
          w = inq[g_m][0];
          e.d = ref_enc(w.d, carry_m);
          e.l = w.l; e.c = g_m;
          e.g_en = w.g_en; e.g = w.g;
          sb.push_back(e);
          acc_cnt++;
          carry_m = int'(w.d[1:0]);
          if (w.l) begin
            idle_m = 1;
            ls_m = g_m;
          end
        end
      end
    end
  end

  task automatic push_word(input int ch, input logic [15:0] d,
                           input logic l, input bit ge,
                           input logic [15:0] g);
    wrd_t x;
    x.d = d; x.l = l; x.g_en = ge; x.g = g;
    inq[ch].push_back(x);
  endtask

  task automatic push_frame(input int ch, input int len);
    for (int i = 0; i < len; i++)
      push_word(ch, 16'($urandom()), (i == len - 1), 0, 0);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (inq[0].size() == 0 && inq[1].size() == 0 &&
          sb.size() == 0 && !m_valid)
        return;
    end
    chk(0, "drain_timeout", 32'(sb.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 0;
    inq[0].delete(); inq[1].delete();
    sv[0] = 0; sv[1] = 0;
  endtask

  int base;
  bit seen;

  initial begin
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(!m_valid && m_data == 0 && !m_last && !m_ch,
        "reset_out", 32'({m_valid, m_last, m_ch, m_data}), 0);
    chk(!srdy[0] && !srdy[1], "reset_ready",
        32'({srdy[1], srdy[0]}), 0);
    chk(!busy, "reset_busy", 32'(busy), 0);
    @(posedge clk); #2 rst_n = 1;

    push_word(0, 16'b10_11_11_00_00_01_10_00, 1, 1,
              16'b10_01_00_01_00_01_01_10);
    drain(100);

    push_word(0, 16'b10_11_11_00_00_01_10_00, 0, 1,
              16'b10_01_00_01_00_01_01_10);
    push_word(0, 16'b00_11_10_01_00_11_10_01, 1, 1,
              16'b00_11_11_11_11_11_11_11);
    drain(100);

    push_word(0, 16'h0003, 0, 1, 16'h0003);
    push_word(0, 16'b01_00_00_00_00_00_00_00, 1, 1,
              16'b10_11_00_00_00_00_00_00);
    drain(100);

    do_reset();
    base = frame_order.size();
    push_frame(0, 2); push_frame(0, 2); push_frame(1, 2);
    @(posedge clk); @(posedge clk); #2 rst_n = 1;
    drain(200);
    chk(frame_order.size() >= base + 3, "order_count",
        32'(frame_order.size() - base), 3);
    if (frame_order.size() >= base + 3) begin
      chk(frame_order[base] == 0, "order0",
          32'(frame_order[base]), 0);
      chk(frame_order[base+1] == 1, "order1",
          32'(frame_order[base+1]), 1);
      chk(frame_order[base+2] == 0, "order2",
          32'(frame_order[base+2]), 0);
    end

    push_frame(0, 3);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = m_valid;
    end
    chk(seen, "bp_wait_valid", 32'(seen), 1);
    @(posedge clk); #2;
    mr_mode = 2; m_ready = 0;
    repeat (3) @(negedge clk);
    mr_mode = 1;
    @(negedge clk);
    chk(m_valid && m_ready && sv[0] && srdy[0],
        "drain_and_accept",
        32'({m_valid, m_ready, sv[0], srdy[0]}), 32'hF);
    drain(100);

    push_word(0, 16'h0003, 0, 0, 0);
    push_frame(0, 2);
    base = acc_cnt;
    for (int i = 0; i < 50 && acc_cnt == base; i++)
      @(negedge clk);
    chk(acc_cnt > base, "rst_wait_acc", 32'(acc_cnt), 1);
    do_reset();
    @(posedge clk); #2 rst_n = 1;
    @(negedge clk);
    chk(!m_valid && !busy, "midframe_reset",
        32'({m_valid, busy}), 0);
    push_word(0, 16'b01_00_00_00_00_00_00_00, 1, 1,
              16'b01_11_00_00_00_00_00_00);
    drain(100);

    vmode = 0; mr_mode = 0;
    for (int i = 0; i < 40; i++)
      push_frame($urandom_range(1), $urandom_range(4, 1));
    drain(5000);
    mr_mode = 1;
    drain(100);
    chk(sb.size() == 0, "sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got %0d want 0", checks);
    $fatal(1, "timeout");
  end

endmodule
